// File: rtl/swap_unit.sv
// Register-bank manipulation unit: SWAP, MOVE, LOADOR and CLEAR on a
// NUM_REGS x WIDTH bank, sequenced through a temp register.
module swap_unit #(
    parameter int WIDTH    = 16,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [WIDTH-1:0]  load_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] NREGS = NUM_REGS[ADDR_W:0];

    localparam logic [1:0] OP_SWAP   = 2'b00;
    localparam logic [1:0] OP_MOVE   = 2'b01;
    localparam logic [1:0] OP_LOADOR = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WR_A,
        WR_B,
        FIN
    } state_t;

    state_t            state;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] a_q;
    logic [ADDR_W-1:0] b_q;
    logic [WIDTH-1:0]  ld_q;
    logic [WIDTH-1:0]  temp;
    logic [WIDTH-1:0]  regs [DEPTH];

    logic a_bad;
    logic b_bad;
    logic pair_op;
    logic bad;

    always_comb begin
        a_bad   = {1'b0, addr_a} >= NREGS;
        b_bad   = {1'b0, addr_b} >= NREGS;
        pair_op = (op == OP_SWAP) || (op == OP_MOVE);
        bad     = a_bad || (pair_op && b_bad);
    end

    // Entries at or above NUM_REGS exist only to keep indexing full-width.
    always_comb begin
        rd_data = '0;
        if ({1'b0, rd_addr} < NREGS)
            rd_data = regs[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            ld_q  <= '0;
            temp  <= '0;
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_q <= op;
                        a_q  <= addr_a;
                        b_q  <= addr_b;
                        ld_q <= load_data;
                        busy <= 1'b1;
                        unique case (1'b1)
                            bad: begin
                                state <= FIN;
                                done  <= 1'b1;
                                err   <= 1'b1;
                            end
                            (!bad && pair_op):  state <= FETCH;
                            (!bad && !pair_op): state <= WR_A;
                        endcase
                    end
                end
                FETCH: begin
                    temp  <= regs[a_q];
                    state <= (op_q == OP_SWAP) ? WR_A : WR_B;
                end
                WR_A: begin
                    unique case (op_q)
                        OP_SWAP:   regs[a_q] <= regs[b_q];
                        OP_LOADOR: regs[a_q] <= regs[a_q] | ld_q;
                        OP_CLEAR:  regs[a_q] <= '0;
                        default:   ;
                    endcase
                    if (op_q == OP_SWAP) begin
                        state <= WR_B;
                    end else begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end
                WR_B: begin
                    regs[b_q] <= temp;
                    state     <= FIN;
                    done      <= 1'b1;
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    err   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_swap_unit.sv
// Bench for swap_unit: an 8-register and a 6-register instance share
// stimulus; a transaction-level bank model is checked every cycle.
module tb_swap_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [2:0]  a;
    logic [2:0]  b;
    logic [15:0] ld;
    logic [1:0]  bsy;
    logic [1:0]  dn;
    logic [1:0]  er;
    logic [2:0]  rda [2];
    logic [15:0] rdd [2];

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    swap_unit #(.WIDTH(16), .NUM_REGS(8), .ADDR_W(3)) dut8 (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .addr_a(a), .addr_b(b), .load_data(ld),
        .busy(bsy[0]), .done(dn[0]), .err(er[0]),
        .rd_addr(rda[0]), .rd_data(rdd[0])
    );

    swap_unit #(.WIDTH(16), .NUM_REGS(6), .ADDR_W(3)) dut6 (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .addr_a(a), .addr_b(b), .load_data(ld),
        .busy(bsy[1]), .done(dn[1]), .err(er[1]),
        .rd_addr(rda[1]), .rd_data(rdd[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Model: bank contents, cycles left in the current op, result bank.
    logic [15:0] m    [2][8];
    logic [15:0] pend [2][8];
    int          cnt  [2];
    bit          moor [2];
    int          nr   [2];

    initial begin
        nr[0] = 8;
        nr[1] = 6;
        for (int i = 0; i < 2; i++) begin
            cnt[i]  = 0;
            moor[i] = 0;
            for (int j = 0; j < 8; j++) begin
                m[i][j]    = '0;
                pend[i][j] = '0;
            end
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    cnt[i] = 0;
                    for (int j = 0; j < 8; j++) m[i][j] = '0;
                end else if (cnt[i] == 0) begin
                    if (start) begin
                        bit bad;
                        bad = (int'(a) >= nr[i]) ||
                              ((op == 2'd0 || op == 2'd1) && int'(b) >= nr[i]);
                        for (int j = 0; j < 8; j++) pend[i][j] = m[i][j];
                        if (!bad) begin
                            case (op)
                                2'd0: begin
                                    pend[i][a] = m[i][b];
                                    pend[i][b] = m[i][a];
                                end
                                2'd1: pend[i][b] = m[i][a];
                                2'd2: pend[i][a] = m[i][a] | ld;
                                default: pend[i][a] = '0;
                            endcase
                        end
                        moor[i] = bad;
                        cnt[i]  = bad ? 1 : (op == 2'd0) ? 4 : (op == 2'd1) ? 3 : 2;
                    end
                end else begin
                    cnt[i]--;
                    if (cnt[i] == 0)
                        for (int j = 0; j < 8; j++) m[i][j] = pend[i][j];
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int i = 0; i < 2; i++) begin
                    string s;
                    s = (i == 0) ? "n8" : "n6";
                    check({"busy_", s}, 32'(bsy[i]), 32'(cnt[i] > 0));
                    check({"done_", s}, 32'(dn[i]), 32'(cnt[i] == 1));
                    check({"err_", s}, 32'(er[i]), 32'(cnt[i] == 1 && moor[i]));
                    if (cnt[i] == 0)
                        check({"rd_", s}, 32'(rdd[i]),
                              (int'(rda[i]) < nr[i]) ? 32'(m[i][rda[i]]) : 32'h0);
                end
            end
        end
    end

    int lat;
    bit c1_dn6;
    bit c1_er6;
    bit last_er;

    task automatic issue(input logic [1:0] o, input logic [2:0] aa,
                         input logic [2:0] bb, input logic [15:0] d);
        @(posedge clk); #1;
        start = 1'b1; op = o; a = aa; b = bb; ld = d;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        lat = 1;
        @(negedge clk);
        c1_dn6 = dn[1];
        c1_er6 = er[1];
        while (!dn[0] && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        last_er = er[0];
        @(posedge clk); #1;
    endtask

    task automatic run(input logic [1:0] o, input logic [2:0] aa,
                       input logic [2:0] bb, input logic [15:0] d,
                       input int explat, input string nm);
        issue(o, aa, bb, d);
        wait_done();
        check(nm, 32'(lat), 32'(explat));
    endtask

    task automatic rd(input int i, input logic [2:0] ad,
                      input logic [15:0] exp, input string nm);
        rda[i] = ad;
        @(negedge clk);
        check(nm, 32'(rdd[i]), 32'(exp));
        @(posedge clk); #1;
    endtask

    initial begin
        int ndone;
        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; ld = '0;
        rda[0] = '0; rda[1] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1;

        @(negedge clk);
        check("rst_busy", 32'(bsy), 32'h0);
        check("rst_done", 32'(dn), 32'h0);
        check("rst_err", 32'(er), 32'h0);
        @(posedge clk); #1;
        for (int j = 0; j < 8; j++) begin
            rd(0, 3'(j), 16'h0, "rst_rd8");
            rd(1, 3'(j), 16'h0, "rst_rd6");
        end

        run(2'd2, 3'd2, 3'd0, 16'h1234, 2, "lat_loador_r2");
        run(2'd2, 3'd5, 3'd0, 16'hABCD, 2, "lat_loador_r5");

        issue(2'd0, 3'd2, 3'd5, 16'h0);
        rda[0] = 3'd2;
        rda[1] = 3'd5;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_swap_r2", 32'(rdd[0]), 32'hABCD);
        check("mid_swap_r5", 32'(rdd[1]), 32'hABCD);
        check("swap_not_done_c3", 32'(dn[0]), 32'h0);
        @(negedge clk);
        check("swap_done_c4", 32'(dn[0]), 32'h1);
        @(posedge clk); #1;
        rd(0, 3'd2, 16'hABCD, "swap_r2");
        rd(0, 3'd5, 16'h1234, "swap_r5");
        rd(1, 3'd2, 16'hABCD, "swap6_r2");

        run(2'd2, 3'd3, 3'd0, 16'h00F0, 2, "lat_loador1");
        run(2'd2, 3'd3, 3'd0, 16'h0F00, 2, "lat_loador2");
        rd(0, 3'd3, 16'h0FF0, "loador_r3");
        run(2'd3, 3'd3, 3'd0, 16'hFFFF, 2, "lat_clear");
        rd(0, 3'd3, 16'h0000, "clear_r3");

        run(2'd2, 3'd1, 3'd0, 16'h5555, 2, "lat_load_r1");
        issue(2'd1, 3'd1, 3'd7, 16'h0);
        ndone = 0;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            start = (k == 2 || k == 3);
            @(negedge clk);
            if (dn[0]) begin
                ndone++;
                if (ndone == 1) lat = k;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("move_lat", 32'(lat), 32'd3);
        check("move_one_done", 32'(ndone), 32'd1);
        rd(0, 3'd7, 16'h5555, "move_r7");
        rd(0, 3'd1, 16'h5555, "move_r1");
        rd(1, 3'd7, 16'h0000, "oor_read6_r7");

        run(2'd0, 3'd2, 3'd6, 16'h0, 4, "lat_swap26");
        check("oor_done_c1", 32'(c1_dn6), 32'h1);
        check("oor_err_c1", 32'(c1_er6), 32'h1);
        rd(1, 3'd2, 16'hABCD, "oor_r2_kept");
        rd(0, 3'd6, 16'hABCD, "swap26_r6");

        run(2'd2, 3'd4, 3'd0, 16'h4444, 2, "lat_load_r4");
        run(2'd0, 3'd4, 3'd4, 16'h0, 4, "lat_swap44");
        check("swap44_err", 32'(last_er), 32'h0);
        rd(0, 3'd4, 16'h4444, "swap44_r4");
        rd(1, 3'd4, 16'h4444, "swap44_r4_6");

        issue(2'd0, 3'd2, 3'd5, 16'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("pre_rst_busy", 32'(bsy[0]), 32'h1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 32'(bsy), 32'h0);
        check("post_rst_done", 32'(dn), 32'h0);
        @(posedge clk); #1;
        for (int j = 0; j < 8; j++)
            rd(0, 3'(j), 16'h0, "post_rst_rd");
        repeat (4) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
